// File: rtl/disp_vram_rdslave_if.sv
// AXI read address/data channel bundle between the display VRAM read master and its VRAM responder.
interface disp_vram_rdslave_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/disp_vram_rdslave.sv
// AXI read responder for display VRAM: 2-deep AR queue, INCR burst issue into a 1-cycle
// synchronous RAM port, 2-deep R output FIFO with full RREADY backpressure.
module disp_vram_rdslave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_AW    = 16
) (
    input  logic               ACLK,
    input  logic               ARST,
    disp_vram_rdslave_if.slave axi,
    output logic [MEM_AW-1:0]  MEM_ADDR,
    output logic               MEM_RE,
    input  logic [63:0]        MEM_RDATA
);
    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [28:0] BASE_W      = BASE_ADDR[31:3];
    localparam logic [29:0] WIN_END     = {1'b0, BASE_W} + (30'd1 << MEM_AW);

    state_t      state_q, state_d;
    logic [28:0] beat_addr_q, beat_addr_d;
    logic [8:0]  beats_left_q, beats_left_d;

    logic [28:0] arq_addr_q [2];
    logic [28:0] arq_addr_d [2];
    logic [7:0]  arq_len_q [2];
    logic [7:0]  arq_len_d [2];
    logic        arq_wr_q, arq_wr_d, arq_rd_q, arq_rd_d;
    logic [1:0]  arq_cnt_q, arq_cnt_d;
    logic        arready_q, arready_d;

    logic [63:0] fifo_data_q [2];
    logic [63:0] fifo_data_d [2];
    logic [1:0]  fifo_resp_q [2];
    logic [1:0]  fifo_resp_d [2];
    logic        fifo_last_q [2];
    logic        fifo_last_d [2];
    logic        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;

    logic        infl_q, infl_d, infl_ok_q, infl_ok_d, infl_last_q, infl_last_d;

    logic        arq_push, arq_pop, in_burst, have_burst, credit, issue, is_last, in_range;
    logic        r_valid, r_pop, fifo_push, fifo_pop;
    logic [28:0] cur_addr;
    logic [8:0]  cur_left;
    logic [63:0] infl_data, r_data;
    logic [1:0]  infl_resp, r_resp;
    logic        r_last;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^axi.ARADDR[2:0];

    // State register
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            beat_addr_q  <= '0;
            beats_left_q <= '0;
            arq_addr_q   <= '{default: '0};
            arq_len_q    <= '{default: '0};
            arq_wr_q     <= 1'b0;
            arq_rd_q     <= 1'b0;
            arq_cnt_q    <= '0;
            arready_q    <= 1'b0;
            fifo_data_q  <= '{default: '0};
            fifo_resp_q  <= '{default: '0};
            fifo_last_q  <= '{default: 1'b0};
            fifo_wr_q    <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_cnt_q   <= '0;
            infl_q       <= 1'b0;
            infl_ok_q    <= 1'b0;
            infl_last_q  <= 1'b0;
        end else begin
            beat_addr_q  <= beat_addr_d;
            beats_left_q <= beats_left_d;
            arq_addr_q   <= arq_addr_d;
            arq_len_q    <= arq_len_d;
            arq_wr_q     <= arq_wr_d;
            arq_rd_q     <= arq_rd_d;
            arq_cnt_q    <= arq_cnt_d;
            arready_q    <= arready_d;
            fifo_data_q  <= fifo_data_d;
            fifo_resp_q  <= fifo_resp_d;
            fifo_last_q  <= fifo_last_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_cnt_q   <= fifo_cnt_d;
            infl_q       <= infl_d;
            infl_ok_q    <= infl_ok_d;
            infl_last_q  <= infl_last_d;
        end
    end

    // Next-state: in IDLE the first beat issues straight from the queue head so the
    // RAM read starts the cycle after the AR handshake.
    always_comb begin
        in_burst   = (state_q == S_BURST);
        have_burst = in_burst || (arq_cnt_q != 2'd0);
        cur_addr   = in_burst ? beat_addr_q : arq_addr_q[arq_rd_q];
        cur_left   = in_burst ? beats_left_q : {1'b0, arq_len_q[arq_rd_q]} + 9'd1;
        r_valid    = (fifo_cnt_q != 2'd0) || infl_q;
        r_pop      = r_valid && axi.RREADY;
        credit     = ({1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, r_pop}) < 3'd2;
        issue      = have_burst && credit;
        is_last    = (cur_left == 9'd1);
        in_range   = ({1'b0, cur_addr} >= {1'b0, BASE_W}) && ({1'b0, cur_addr} < WIN_END);
        arq_pop    = issue && (!in_burst || (is_last && arq_cnt_q != 2'd0));

        state_d      = state_q;
        beat_addr_d  = beat_addr_q;
        beats_left_d = beats_left_q;
        if (issue) begin
            if (!is_last) begin
                state_d      = S_BURST;
                beat_addr_d  = cur_addr + 29'd1;
                beats_left_d = cur_left - 9'd1;
            end else if (in_burst && arq_cnt_q != 2'd0) begin
                state_d      = S_BURST;
                beat_addr_d  = arq_addr_q[arq_rd_q];
                beats_left_d = {1'b0, arq_len_q[arq_rd_q]} + 9'd1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        arq_push   = axi.ARVALID && arready_q;
        arq_addr_d = arq_addr_q;
        arq_len_d  = arq_len_q;
        arq_wr_d   = arq_wr_q;
        arq_rd_d   = arq_rd_q;
        if (arq_push) begin
            arq_addr_d[arq_wr_q] = axi.ARADDR[31:3];
            arq_len_d[arq_wr_q]  = axi.ARLEN;
            arq_wr_d             = ~arq_wr_q;
        end
        if (arq_pop) arq_rd_d = ~arq_rd_q;
        arq_cnt_d = arq_cnt_q + {1'b0, arq_push} - {1'b0, arq_pop};
        arready_d = (arq_cnt_d < 2'd2);

        infl_d      = issue;
        infl_ok_d   = issue && in_range;
        infl_last_d = issue && is_last;
        infl_data   = infl_ok_q ? MEM_RDATA : '0;
        infl_resp   = infl_ok_q ? RESP_OKAY : RESP_SLVERR;

        // An in-flight beat skips the FIFO when it is empty and the master is ready.
        fifo_push   = infl_q && !((fifo_cnt_q == 2'd0) && axi.RREADY);
        fifo_pop    = (fifo_cnt_q != 2'd0) && axi.RREADY;
        fifo_data_d = fifo_data_q;
        fifo_resp_d = fifo_resp_q;
        fifo_last_d = fifo_last_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        if (fifo_push) begin
            fifo_data_d[fifo_wr_q] = infl_data;
            fifo_resp_d[fifo_wr_q] = infl_resp;
            fifo_last_d[fifo_wr_q] = infl_last_q;
            fifo_wr_d              = ~fifo_wr_q;
        end
        if (fifo_pop) fifo_rd_d = ~fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end

    // Outputs
    always_comb begin
        MEM_RE   = issue && in_range;
        MEM_ADDR = MEM_RE ? MEM_AW'(cur_addr - BASE_W) : '0;
        r_data   = '0;
        r_resp   = RESP_OKAY;
        r_last   = 1'b0;
        if (fifo_cnt_q != 2'd0) begin
            r_data = fifo_data_q[fifo_rd_q];
            r_resp = fifo_resp_q[fifo_rd_q];
            r_last = fifo_last_q[fifo_rd_q];
        end else if (infl_q) begin
            r_data = infl_data;
            r_resp = infl_resp;
            r_last = infl_last_q;
        end
    end

    assign axi.ARREADY = arready_q;
    assign axi.RVALID  = r_valid;
    assign axi.RDATA   = r_data;
    assign axi.RRESP   = r_resp;
    assign axi.RLAST   = r_last;
endmodule
